// File: rtl/ramp_counter.sv
// Ramp counter with saturate, wrap and bounce modes between runtime limits.
// Synchronous active-high reset; limits and step may change every cycle.
module ramp_counter #(
  parameter int BITS      = 8,
  parameter int STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic                 dir_in,
  input  logic [STEP_BITS-1:0] step,
  input  logic [BITS-1:0]      lo,
  input  logic [BITS-1:0]      hi,
  input  logic                 load,
  input  logic [BITS-1:0]      load_value,
  output logic [BITS-1:0]      out,
  output logic                 dir,
  output logic                 at_lo,
  output logic                 at_hi,
  output logic                 turn,
  output logic                 wrapped,
  output logic                 cfg_err
);

  localparam int W = BITS + 1;

  typedef enum logic [1:0] {
    M_SAT  = 2'd0,
    M_WRAP = 2'd1,
    M_BNC  = 2'd2,
    M_HOLD = 2'd3
  } mode_t;

  mode_t          md;
  logic [W-1:0]   o_w;
  logic [W-1:0]   s_w;
  logic [W-1:0]   lo_w;
  logic [W-1:0]   hi_w;
  logic [W-1:0]   up_sum;
  logic [W-1:0]   dn_dif;
  logic [W-1:0]   lo_sum;
  logic           up_ovr;
  logic           dn_und;
  logic [BITS-1:0] out_n;
  logic           dir_n;
  logic           turn_n;
  logic           wrap_n;
  logic [BITS-1:0] ld_clamp;

  assign md      = mode_t'(mode);
  assign o_w     = {1'b0, out};
  assign s_w     = W'(step);
  assign lo_w    = {1'b0, lo};
  assign hi_w    = {1'b0, hi};
  assign up_sum  = o_w + s_w;
  assign dn_dif  = o_w - s_w;
  assign lo_sum  = lo_w + s_w;
  // Widened compares keep out+step / out-step from ever aliasing.
  assign up_ovr  = up_sum > hi_w;
  assign dn_und  = o_w < lo_sum;

  assign cfg_err = lo > hi;
  assign at_lo   = out == lo;
  assign at_hi   = out == hi;

  always_comb begin
    ld_clamp = load_value;
    if (load_value < lo)
      ld_clamp = lo;
    else if (load_value > hi)
      ld_clamp = hi;
  end

  always_comb begin
    out_n  = out;
    dir_n  = dir;
    turn_n = 1'b0;
    wrap_n = 1'b0;
    if (cfg_err) begin
      out_n = out;
    end else if (load) begin
      out_n = ld_clamp;
    end else if (en) begin
      if (out < lo) begin
        out_n = lo;
      end else if (out > hi) begin
        out_n = hi;
      end else if (step != '0) begin
        case (md)
          M_SAT: begin
            if (!dir_in)
              out_n = up_ovr ? hi : up_sum[BITS-1:0];
            else
              out_n = dn_und ? lo : dn_dif[BITS-1:0];
          end
          M_WRAP: begin
            if (!dir_in) begin
              out_n  = up_ovr ? lo : up_sum[BITS-1:0];
              wrap_n = up_ovr;
            end else begin
              out_n  = dn_und ? hi : dn_dif[BITS-1:0];
              wrap_n = dn_und;
            end
          end
          M_BNC: begin
            if (!dir) begin
              if (up_sum >= hi_w) begin
                out_n  = hi;
                dir_n  = 1'b1;
                turn_n = 1'b1;
              end else begin
                out_n = up_sum[BITS-1:0];
              end
            end else begin
              if (o_w <= lo_sum) begin
                out_n  = lo;
                dir_n  = 1'b0;
                turn_n = 1'b1;
              end else begin
                out_n = dn_dif[BITS-1:0];
              end
            end
          end
          default: out_n = out;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      dir     <= 1'b0;
      turn    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      out     <= out_n;
      dir     <= dir_n;
      turn    <= turn_n;
      wrapped <= wrap_n;
    end
  end

endmodule

// File: tb/tb_ramp_counter.sv
// Bench for ramp_counter: directed ramps plus random traffic
// against an integer-arithmetic reference model.
module tb_ramp_counter;

  localparam int BITS = 8;
  localparam int SB   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [1:0]      mode;
  logic            dir_in;
  logic [SB-1:0]   step;
  logic [BITS-1:0] lo;
  logic [BITS-1:0] hi;
  logic            load;
  logic [BITS-1:0] load_value;
  logic [BITS-1:0] out;
  logic            dir;
  logic            at_lo;
  logic            at_hi;
  logic            turn;
  logic            wrapped;
  logic            cfg_err;

  int vectors = 0;
  int miscompares = 0;
  int m_out, m_dir, m_turn, m_wrap;

  ramp_counter #(.BITS(BITS), .STEP_BITS(SB)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .dir_in(dir_in), .step(step), .lo(lo), .hi(hi),
    .load(load), .load_value(load_value), .out(out),
    .dir(dir), .at_lo(at_lo), .at_hi(at_hi), .turn(turn),
    .wrapped(wrapped), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Next state from the rules, using plain signed integers.
  task automatic model_step();
    int l, h, o, s;
    l = lo; h = hi; o = m_out; s = step;
    m_turn = 0;
    m_wrap = 0;
    if (reset) begin
      m_out = 0;
      m_dir = 0;
    end else if (l > h) begin
    end else if (load) begin
      m_out = (load_value < l) ? l :
              (load_value > h) ? h : int'(load_value);
    end else if (en) begin
      if (o < l) m_out = l;
      else if (o > h) m_out = h;
      else if (s == 0 || mode == 2'd3) begin
      end else if (mode == 2'd0) begin
        if (!dir_in) m_out = (o + s > h) ? h : o + s;
        else         m_out = (o - s < l) ? l : o - s;
      end else if (mode == 2'd1) begin
        if (!dir_in) begin
          if (o + s > h) begin m_out = l; m_wrap = 1; end
          else m_out = o + s;
        end else begin
          if (o - s < l) begin m_out = h; m_wrap = 1; end
          else m_out = o - s;
        end
      end else begin
        if (m_dir == 0) begin
          if (o + s >= h) begin
            m_out = h; m_dir = 1; m_turn = 1;
          end else m_out = o + s;
        end else begin
          if (o - s <= l) begin
            m_out = l; m_dir = 0; m_turn = 1;
          end else m_out = o - s;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out", 32'(out), 32'(m_out));
    check("dir", 32'(dir), 32'(m_dir));
    check("turn", 32'(turn), 32'(m_turn));
    check("wrapped", 32'(wrapped), 32'(m_wrap));
    check("at_lo", 32'(at_lo), 32'(m_out == int'(lo)));
    check("at_hi", 32'(at_hi), 32'(m_out == int'(hi)));
    check("cfg_err", 32'(cfg_err), 32'(lo > hi));
  endtask

  int exp37[4]  = '{14, 18, 10, 14};
  int wex37[4]  = '{0, 0, 1, 0};
  int exp38[8]  = '{3, 6, 9, 10, 7, 4, 1, 0};
  int tex38[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
  int dex38[8]  = '{0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    m_out = 0; m_dir = 0; m_turn = 0; m_wrap = 0;
    reset = 1'b1; en = 1'b0; mode = 2'd0; dir_in = 1'b0;
    step = 4'd1; lo = 8'd0; hi = 8'd255;
    load = 1'b0; load_value = 8'd0;
    #2;
    tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);

    // Saturating up-ramp over the full range.
    reset = 1'b0; en = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      if (c == 254) check("sat_254", 32'(out), 32'd254);
      if (c == 255) check("sat_255", 32'(out), 32'd255);
    end
    check("sat_hold", 32'(out), 32'd255);
    check("sat_nopulse", 32'(turn | wrapped), 32'd0);

    // Wrap up between 10 and 20.
    mode = 2'd1; lo = 8'd10; hi = 8'd20; step = 4'd4;
    load = 1'b1; load_value = 8'd10;
    tick();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_out", 32'(out), 32'(exp37[i]));
      check("wrap_pulse", 32'(wrapped), 32'(wex37[i]));
    end

    // Bounce 0..10 step 3 from a fresh reset.
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 2'd2; lo = 8'd0; hi = 8'd10; step = 4'd3;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bnc_out", 32'(out), 32'(exp38[i]));
      check("bnc_turn", 32'(turn), 32'(tex38[i]));
      check("bnc_dir", 32'(dir), 32'(dex38[i]));
    end

    // Climb to 7 heading down, then reset mid-ramp.
    for (int i = 0; i < 5; i++) tick();
    check("mid_out", 32'(out), 32'd7);
    check("mid_dir", 32'(dir), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_out", 32'(out), 32'd0);
    check("mrst_dir", 32'(dir), 32'd0);
    check("mrst_pls", 32'(turn | wrapped), 32'd0);
    lo = 8'd5;
    tick();
    check("clamp_lo", 32'(out), 32'd5);

    // Load clamps; inverted limits freeze the count.
    mode = 2'd0; dir_in = 1'b0; lo = 8'd0; hi = 8'd100;
    load = 1'b1; load_value = 8'd200;
    tick();
    check("ld_clamp", 32'(out), 32'd100);
    check("ld_pulse", 32'(turn | wrapped), 32'd0);
    load = 1'b0; lo = 8'd50; hi = 8'd40;
    #1;
    check("cfg_err", 32'(cfg_err), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("cfg_frz", 32'(out), 32'd100);

    // Random traffic with slowly changing limits and mode.
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) begin
        if ($urandom_range(0, 7) == 0) begin
          hi = 8'($urandom_range(0, 200));
          lo = hi + 8'($urandom_range(1, 50));
        end else begin
          lo = 8'($urandom_range(0, 200));
          hi = lo + 8'($urandom_range(0, 55));
        end
      end
      if (c % 16 == 0) mode = 2'($urandom_range(0, 3));
      dir_in = 1'($urandom);
      step = 4'($urandom);
      en = ($urandom_range(0, 9) < 8);
      load = (lo <= hi) && ($urandom_range(0, 19) == 0);
      load_value = 8'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
